button_bank: RTL and testbench

Parametrised multi-channel button front end that replaces the per-button debounce FSMs in the board top level. It synchronises N_CH raw push-button/switch inputs into the clock domain, debounces each channel independently and emits one-cycle press/release strobes. It optionally emits auto-repeat strobes while a button is held. Outputs feed the control datapath (AES_Encoder) and DisplayController directly on the 25 MHz system clock.

---
 rtl/button_bank.sv | 152 +++++++++++++++
 tb/tb_button_bank.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// button_bank: N_CH-channel synchroniser, debouncer and press/release strobe generator.
// Define BTN_REPEAT_EN to build the per-channel auto-repeat FSM; otherwise repeat_o is 0.
module button_bank #(
    parameter int unsigned     N_CH       = 4,
    parameter int unsigned     DB_CYCLES  = 250000,
    parameter int unsigned     REP_DELAY  = 12500000,
    parameter int unsigned     REP_PERIOD = 2500000,
    parameter logic [N_CH-1:0] POL        = {N_CH{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o
);

    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [DW-1:0] DB_TOP = DW'(DB_CYCLES - 1);

`ifdef BTN_REPEAT_EN
    localparam int unsigned RMAX =
        (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_TOP = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RP_TOP = RW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rep_state_e;
`endif

    // Polarity-normalised so that 1 is always "pressed"
    logic [N_CH-1:0] w_norm;
    assign w_norm = btn_i ^ ~POL;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic          r_s1;
        logic          r_s2;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic [DW-1:0] r_dcnt;
        logic          w_toggle;
        logic          w_rise;
        logic          w_fall;
        logic          w_rep;

        assign w_toggle = (r_s2 != r_level) && (r_dcnt == DB_TOP);
        assign w_rise   = w_toggle && !r_level;
        assign w_fall   = w_toggle && r_level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_dcnt    <= '0;
            end else begin
                r_s1      <= w_norm[gi];
                r_s2      <= r_s1;
                r_press   <= w_rise;
                r_release <= w_fall;
                if (r_s2 == r_level) begin
                    r_dcnt <= '0;
                end else if (w_toggle) begin
                    r_level <= ~r_level;
                    r_dcnt  <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DW'(1);
                end
            end
        end

`ifdef BTN_REPEAT_EN
        rep_state_e    r_state;
        rep_state_e    w_state_nxt;
        logic [RW-1:0] r_rcnt;
        logic [RW-1:0] w_rcnt_nxt;
        logic          r_rep;
        logic          w_rep_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_rcnt  <= '0;
                r_rep   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_rcnt  <= w_rcnt_nxt;
                r_rep   <= w_rep_nxt;
            end
        end

        // Driven by the debounce edge so repeat timing is relative to press_o
        always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            w_rep_nxt   = 1'b0;
            if (w_fall) begin
                w_state_nxt = ST_IDLE;
                w_rcnt_nxt  = '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            w_state_nxt = ST_DELAY;
                            w_rcnt_nxt  = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (r_rcnt == RD_TOP) begin
                            w_rep_nxt   = 1'b1;
                            w_rcnt_nxt  = '0;
                            w_state_nxt = ST_REPEAT;
                        end else begin
                            w_rcnt_nxt = r_rcnt + RW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (r_rcnt == RP_TOP) begin
                            w_rep_nxt  = 1'b1;
                            w_rcnt_nxt = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + RW'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_rcnt_nxt  = '0;
                    end
                endcase
            end
        end

        assign w_rep = r_rep;
`else
        assign w_rep = 1'b0;
`endif

        assign level_o[gi]   = r_level;
        assign press_o[gi]   = r_press;
        assign release_o[gi] = r_release;
        assign repeat_o[gi]  = w_rep;
    end

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: scoreboard bench for button_bank (DB=4, REP_DELAY=10, REP_PERIOD=3).
// Expected strobes are queued with their due cycle when buttons are driven.
module tb_button_bank;

    localparam int          N_CH = 4;
    localparam int          DB   = 4;
    localparam int          RD   = 10;
    localparam int          RP   = 3;
    localparam logic [3:0]  POL  = 4'b0111;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] btn_i = 4'b1000;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] repeat_o;

    button_bank #(
        .N_CH      (N_CH),
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP),
        .POL       (POL)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_i    (btn_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .repeat_o (repeat_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int          ch;
        int          kind;
    } evt_t;

    evt_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  exp_level = '0;
    logic [3:0]  ep, er, eq;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_press(input int ch, input int unsigned c);
        sb.push_back('{c, ch, 0});
`ifdef BTN_REPEAT_EN
        for (int unsigned r = c + RD; r < c + 300; r += RP)
            sb.push_back('{r, ch, 2});
`endif
    endtask

    task automatic push_release(input int ch, input int unsigned c);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].ch == ch && sb[i].kind == 2 && sb[i].cyc >= c)
                sb.delete(i);
        sb.push_back('{c, ch, 1});
    endtask

    // Called just after a negedge; first sampling edge is cyc+1
    task automatic set_btn(input int ch, input bit act);
        btn_i[ch] = POL[ch] ? act : !act;
        if (act) push_press(ch, cyc + 1 + DB + 1);
        else     push_release(ch, cyc + 1 + DB + 1);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        ep = '0;
        er = '0;
        eq = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    0:       ep[sb[i].ch] = 1'b1;
                    1:       er[sb[i].ch] = 1'b1;
                    default: eq[sb[i].ch] = 1'b1;
                endcase
                sb.delete(i);
            end
        end
        exp_level = (exp_level | ep) & ~er;
        check("outputs", {16'h0, level_o, press_o, release_o, repeat_o},
              {16'h0, exp_level, ep, er, eq});
    end

    initial begin
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(3);

        // clean press on ch0, held long enough to auto-repeat
        set_btn(0, 1'b1);
        wait_neg(35);
        set_btn(0, 1'b0);
        wait_neg(12);

        // bouncing ch1 must not register, then a stable press does
        repeat (5) begin
            btn_i[1] = 1'b1;
            wait_neg(3);
            btn_i[1] = 1'b0;
            wait_neg(1);
        end
        set_btn(1, 1'b1);
        wait_neg(11);
        set_btn(1, 1'b0);
        wait_neg(12);

        // active-low ch3; release lands on the first-repeat cycle
        set_btn(3, 1'b1);
        wait_neg(10);
        set_btn(3, 1'b0);
        wait_neg(12);

        // simultaneous channels
        set_btn(0, 1'b1);
        set_btn(2, 1'b1);
        wait_neg(20);
        set_btn(0, 1'b0);
        set_btn(2, 1'b0);
        wait_neg(12);

        // reset while ch0/ch2 are in REPEAT
        set_btn(0, 1'b1);
        set_btn(2, 1'b1);
        wait_neg(20);
        rst_n = 1'b0;
        sb.delete();
        exp_level = '0;
        #1;
        check("rst_async", {16'h0, level_o, press_o, release_o, repeat_o},
              32'h0);
        wait_neg(1);
        btn_i[2] = POL[2] ? 1'b0 : 1'b1;
        wait_neg(2);
        rst_n = 1'b1;
        push_press(0, cyc + 1 + DB + 1);
        wait_neg(25);
        set_btn(0, 1'b0);
        wait_neg(12);

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
